// File: rtl/pc_sequencer_if.sv
// Decode <-> fetch-sequencer channel: redirect handshake in, fetch address and status out.
interface pc_sequencer_if;
  logic        stall;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [1:0]  redirect_type;
  logic [25:0] jump_index;
  logic [31:0] reg_target;
  logic [15:0] branch_offset;
  logic [31:0] PC;
  logic [31:0] PC2;
  logic        fetch_valid;
  logic        misalign;
  logic [31:0] bad_addr;

  // decode side drives redirects and stall
  modport master (
    output stall, redirect_valid, redirect_type, jump_index, reg_target, branch_offset,
    input  redirect_ready, PC, PC2, fetch_valid, misalign, bad_addr
  );

  modport slave (
    input  stall, redirect_valid, redirect_type, jump_index, reg_target, branch_offset,
    output redirect_ready, PC, PC2, fetch_valid, misalign, bad_addr
  );
endinterface

// File: rtl/pc_sequencer.sv
// MIPS fetch PC sequencer: sequential fetch, J/JR/branch redirects with one bubble,
// misaligned JR targets vector to EXC_VECTOR.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {HOLD, RUN, BUBBLE, EXC} state_e;

  localparam logic [1:0] T_J  = 2'b00;
  localparam logic [1:0] T_JR = 2'b01;
  localparam logic [1:0] T_BR = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] bad_q, bad_d;
  logic        fv_q, fv_d;
  logic        mis_q, mis_d;

  logic [31:0] pc2;
  logic [31:0] target;
  logic        accept;
  logic        jr_bad;

  assign pc2    = pc_q + 32'd4;
  assign accept = (state_q == RUN) && bus.redirect_valid && (bus.redirect_type != 2'b11);
  assign jr_bad = (bus.redirect_type == T_JR) && (bus.reg_target[1:0] != 2'b00);

  // J region comes from PC2, so a J in the last slot of a region lands in the next one
  always_comb begin
    target = pc2;
    case (bus.redirect_type)
      T_J:     target = {pc2[31:28], bus.jump_index, 2'b00};
      T_JR:    target = bus.reg_target;
      T_BR:    target = pc2 + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
      default: target = pc2;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HOLD;
      pc_q    <= RESET_PC;
      bad_q   <= 32'd0;
      fv_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
      fv_q    <= fv_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:    state_d = RUN;
      RUN:     if (accept) state_d = jr_bad ? EXC : BUBBLE;
      BUBBLE:  state_d = RUN;
      EXC:     state_d = RUN;
      default: state_d = HOLD;
    endcase
  end

  // redirect wins over stall; BUBBLE/EXC/HOLD keep PC on the target
  always_comb begin
    pc_d  = pc_q;
    bad_d = bad_q;
    mis_d = 1'b0;
    if (state_q == RUN) begin
      if (accept) begin
        if (jr_bad) begin
          pc_d  = EXC_VECTOR;
          bad_d = bus.reg_target;
          mis_d = 1'b1;
        end else begin
          pc_d  = target;
        end
      end else if (!bus.stall) begin
        pc_d = pc2;
      end
    end
    fv_d = (state_d == RUN);
  end

  assign bus.PC             = pc_q;
  assign bus.PC2            = pc2;
  assign bus.fetch_valid    = fv_q;
  assign bus.misalign       = mis_q;
  assign bus.bad_addr       = bad_q;
  assign bus.redirect_ready = (state_q == RUN);
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected post-edge state queued per step, checked after the edge.
module tb_pc_sequencer;
  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        rr;
    logic        mis;
    logic [31:0] bad;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  pc_sequencer_if bus ();
  pc_sequencer u_dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".pc"},  bus.PC, e.pc);
    chk({tag, ".pc2"}, bus.PC2, e.pc + 32'd4);
    chk({tag, ".fv"},  {31'd0, bus.fetch_valid}, {31'd0, e.fv});
    chk({tag, ".rr"},  {31'd0, bus.redirect_ready}, {31'd0, e.rr});
    chk({tag, ".mis"}, {31'd0, bus.misalign}, {31'd0, e.mis});
    chk({tag, ".bad"}, bus.bad_addr, e.bad);
  endtask

  task automatic expect_now(input string tag, input logic [31:0] pc, input logic fv,
                            input logic rr, input logic mis, input logic [31:0] bad);
    sb.push_back('{pc, fv, rr, mis, bad});
    compare(tag);
  endtask

  // push expectation for the state after the next edge, then check it at edge+1
  task automatic cyc(input string tag, input logic [31:0] pc, input logic fv,
                     input logic rr, input logic mis, input logic [31:0] bad);
    sb.push_back('{pc, fv, rr, mis, bad});
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic redir(input logic [1:0] t, input logic [25:0] ji,
                       input logic [31:0] rt, input logic [15:0] bo);
    bus.redirect_valid = 1'b1;
    bus.redirect_type  = t;
    bus.jump_index     = ji;
    bus.reg_target     = rt;
    bus.branch_offset  = bo;
  endtask

  task automatic idle();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] bad;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_type = 2'b00;
    bus.jump_index = '0;
    bus.reg_target = '0;
    bus.branch_offset = '0;
    bad = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    expect_now("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    expect_now("hold", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("seq0", 32'h0, 1, 1, 0, bad);
    cyc("seq4", 32'h4, 1, 1, 0, bad);
    cyc("seq8", 32'h8, 1, 1, 0, bad);
    cyc("seqC", 32'hC, 1, 1, 0, bad);

    // J-type redirect from 0x1000_0010
    redir(2'b01, '0, 32'h1000_0010, '0);
    cyc("jr_set", 32'h1000_0010, 0, 0, 0, bad);
    idle();
    cyc("jr_run", 32'h1000_0010, 1, 1, 0, bad);
    redir(2'b00, 26'h0000_040, '0, '0);
    cyc("j_bub", 32'h1000_0100, 0, 0, 0, bad);
    idle();
    cyc("j_run", 32'h1000_0100, 1, 1, 0, bad);
    cyc("j_next", 32'h1000_0104, 1, 1, 0, bad);

    // backward branch under stall
    redir(2'b01, '0, 32'h0000_0020, '0);
    cyc("set20", 32'h20, 0, 0, 0, bad);
    idle();
    cyc("run20", 32'h20, 1, 1, 0, bad);
    bus.stall = 1'b1;
    redir(2'b10, '0, '0, 16'hFFFC);
    cyc("br_bub", 32'h14, 0, 0, 0, bad);
    idle();
    cyc("br_run", 32'h14, 1, 1, 0, bad);
    cyc("stall_hold", 32'h14, 1, 1, 0, bad);
    bus.stall = 1'b0;
    redir(2'b11, 26'h3FF_FFFF, 32'h1234_5678, 16'h1234);
    cyc("reserved", 32'h18, 1, 1, 0, bad);

    // misaligned JR, redirect presented during EXC is dropped
    redir(2'b01, '0, 32'h0040_0002, '0);
    bad = 32'h0040_0002;
    cyc("exc", 32'h80, 0, 0, 1, bad);
    redir(2'b00, 26'h0000_123, '0, '0);
    cyc("exc_ign", 32'h80, 1, 1, 0, bad);
    idle();
    cyc("exc_next", 32'h84, 1, 1, 0, bad);

    // wrap
    redir(2'b01, '0, 32'hFFFF_FFFC, '0);
    cyc("wrap_bub", 32'hFFFF_FFFC, 0, 0, 0, bad);
    idle();
    cyc("wrap_run", 32'hFFFF_FFFC, 1, 1, 0, bad);
    cyc("wrap0", 32'h0, 1, 1, 0, bad);

    // J region taken from PC2
    redir(2'b01, '0, 32'h0FFF_FFFC, '0);
    cyc("reg_bub", 32'h0FFF_FFFC, 0, 0, 0, bad);
    idle();
    cyc("reg_run", 32'h0FFF_FFFC, 1, 1, 0, bad);
    redir(2'b00, 26'h0, '0, '0);
    cyc("reg_j", 32'h1000_0000, 0, 0, 0, bad);
    idle();

    // async reset in BUBBLE
    #2;
    rst = 1'b1;
    #1;
    expect_now("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_now("rst_hold", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("rst_run", 32'h0, 1, 1, 0, 32'h0);
    cyc("rst_seq", 32'h4, 1, 1, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the MIPS fetch stage: holds the PC, produces PC2 (PC+4), and consumes control-flow redirects from decode. For J-type redirects it forms the target from the 26-bit instruction index and PC2's upper nibble. For branches and JR it forms the target from the offset or the register value. Each redirect costs one fetch bubble, and misaligned JR targets vector to the exception handler.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- EXC_VECTOR, 32'h0000_0080, PC loaded on a misaligned JR target
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hold PC when no redirect is accepted
- redirect_valid  input  1  decode presents a redirect this cycle
- redirect_ready  output  1  sequencer can accept a redirect
- redirect_type  input  2  00 = J, 01 = JR, 10 = branch (taken), 11 = reserved (treated as no redirect)
- jump_index  input  26  J-type instruction index
- reg_target  input  32  JR register value
- branch_offset  input  16  branch immediate, signed
- PC  output  32  current fetch address
- PC2  output  32  PC + 4
- fetch_valid  output  1  PC is a valid fetch this cycle
- misalign  output  1  one-cycle pulse on a rejected JR target
- bad_addr  output  32  last misaligned JR target, held until the next misalign

## Operation
- States:
  - HOLD: first cycle after reset
  - RUN
  - BUBBLE: one cycle after a redirect
  - EXC: one cycle after a misalign
- Reset (async, any time, including mid-redirect):
  - PC = RESET_PC, PC2 = RESET_PC+4, state = HOLD.
  - fetch_valid = 0, redirect_ready = 0, misalign = 0, bad_addr = 0.
- HOLD -> RUN unconditionally on the first clk edge with rst low. PC is unchanged.
- RUN:
  - fetch_valid = 1 and redirect_ready = 1.
  - Accept: redirect_valid && redirect_type != 11 at the edge.
  - Accept with a target that is not misaligned: PC <= target, state -> BUBBLE. Stall is ignored, because a redirect has priority over stall.
  - Accept with JR and reg_target[1:0] != 0: PC <= EXC_VECTOR, bad_addr <= reg_target, misalign = 1 for the following cycle, state -> EXC.
  - No accept, stall = 1: PC holds.
  - No accept, stall = 0: PC <= PC2.
- Target formation (all arithmetic modulo 2^32):
  - J: {PC2[31:28], jump_index, 2'b00}.
  - JR: reg_target, used as-is if aligned.
  - Branch: PC2 + ({{14{branch_offset[15]}}, branch_offset, 2'b00}).
- BUBBLE:
  - fetch_valid = 0 and redirect_ready = 0. Incoming redirects are ignored.
  - PC holds the new target; the state returns to RUN next edge.
  - Stall is ignored.
- EXC: same as BUBBLE, with misalign = 1 during this cycle only; next edge -> RUN.
- PC2 is always combinationally PC + 4. PC = 32'hFFFF_FFFC gives PC2 = 32'h0000_0000.
- J targets take the upper nibble of PC2, not PC. At PC = 32'h0FFF_FFFC the J region is 4'h1.

## Timing
- Sequential fetch: PC advances by 4 per unstalled RUN cycle.
- Redirect latency:
  - Accept at edge N; PC = target is visible after edge N.
  - fetch_valid = 0 between edges N and N+1.
  - Fetch of the target is valid after edge N+1.
- Redirect throughput: at most one per two cycles, because redirect_ready is low during BUBBLE/EXC.
- All outputs are registered except PC2 and redirect_ready, which decode from PC and state.
- fetch_valid is low for exactly one cycle after reset release.

## Test plan
- Reset and sequential fetch:
  - Stimulus: rst high, then release; stall = 0.
  - Response: PC = 0 with fetch_valid = 0 for 1 cycle, then PC = 0, 4, 8, C with fetch_valid = 1.
- J-type redirect:
  - Stimulus: at PC = 32'h1000_0010, J with jump_index = 26'h0000_040.
  - Response: next PC = 32'h1000_0100; one cycle fetch_valid = 0; then PC = 32'h1000_0104.
- Backward branch during stall:
  - Stimulus: stall = 1 at PC = 32'h0000_0020, branch_offset = 16'hFFFC.
  - Response: PC = 32'h0000_0014 after one bubble; stall is ignored for the redirect.
- Misaligned JR, then a redirect during EXC:
  - Stimulus: JR with reg_target = 32'h0040_0002, then a redirect asserted during EXC.
  - Response: PC = 32'h0000_0080, bad_addr = 32'h0040_0002, misalign high 1 cycle, redirect_ready = 0 in EXC, and the redirect in EXC is ignored.
- Wrap and region boundary:
  - Wrap stimulus: PC = 32'hFFFF_FFFC, no stall. Response: next PC = 0.
  - Region stimulus: at PC = 32'h0FFF_FFFC, J with jump_index = 0. Response: target = 32'h1000_0000.
- Reset mid-redirect:
  - Stimulus: assert rst asynchronously during BUBBLE.
  - Response: PC = RESET_PC immediately, fetch_valid = 0, misalign = 0, state HOLD.
